chip8_mem_xfer: RTL and testbench

Bulk transfer engine for the Chip-8 CPU. It executes the multi-byte memory instructions FX55 (store V0..VX), FX65 (load V0..VX) and FX33 (BCD of VX). It initiates accesses on port A of the CPU memory, which has a 1-cycle read latency and silently drops writes below 0x200. It sits between the instruction sequencer (command source) and the register file, so the sequencer stays single-cycle.

---
 rtl/chip8_pkg.sv | 33 +++
 rtl/chip8_bcd_split.sv | 13 +
 rtl/chip8_mem_xfer.sv | 183 ++++++++++++++++++
 tb/tb_chip8_mem_xfer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// Shared Chip-8 definitions: memory-transfer op encodings, protection limit and engine FSM states.
package chip8_pkg;

  localparam int unsigned ADDR_W_DEF     = 12;
  localparam logic [11:0] PROT_LIMIT_DEF = 12'h200;

  typedef enum logic [1:0] {
    OP_STORE = 2'd0,
    OP_LOAD  = 2'd1,
    OP_BCD   = 2'd2,
    OP_NOP   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    STORE     = 3'd1,
    LOAD      = 3'd2,
    LOAD_LAST = 3'd3,
    BCD       = 3'd4,
    DONE      = 3'd5
  } state_e;

  // First working state for a freshly accepted command.
  function automatic state_e op_to_state(input op_e op);
    case (op)
      OP_STORE: op_to_state = STORE;
      OP_LOAD:  op_to_state = LOAD;
      OP_BCD:   op_to_state = BCD;
      default:  op_to_state = DONE;
    endcase
  endfunction

endpackage

// File: rtl/chip8_bcd_split.sv
// Combinational 8-bit binary to three BCD digits (hundreds, tens, ones) by constant division.
module chip8_bcd_split (
  input  logic [7:0] val,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  assign hundreds = 4'(val / 8'd100);
  assign tens     = 4'((val / 8'd10) % 8'd10);
  assign ones     = 4'(val % 8'd10);

endmodule

// File: rtl/chip8_mem_xfer.sv
// Chip-8 bulk memory transfer engine for FX55 / FX65 / FX33 over memory port A.
// Optional macro CHIP8_MEM_XFER_I_INCR_EN: STORE/LOAD update I to I+X+1 on completion.
module chip8_mem_xfer
  import chip8_pkg::*;
#(
  parameter int unsigned         ADDR_W     = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0]   PROT_LIMIT = ADDR_W'(PROT_LIMIT_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [3:0]        cmd_x,
  input  logic [ADDR_W-1:0] cmd_i,
  input  logic [7:0]        cmd_val,
  output logic [3:0]        rf_raddr,
  input  logic [7:0]        rf_rdata,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [7:0]        rf_wdata,
  output logic              mem_en,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              done,
  output logic              prot_hit,
  output logic [ADDR_W-1:0] i_next,
  output logic              i_we
);

  state_e            state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic [3:0]        x_q;
  logic [ADDR_W-1:0] i_q;
  logic [7:0]        val_q;
  logic              prot_q, prot_d;
  logic              accept;
  logic [ADDR_W-1:0] addr_k;
  logic [3:0]        bcd_hun, bcd_ten, bcd_one;
  logic [3:0]        digit;
`ifdef CHIP8_MEM_XFER_I_INCR_EN
  op_e               op_q;
`endif

  chip8_bcd_split u_bcd (
    .val      (val_q),
    .hundreds (bcd_hun),
    .tens     (bcd_ten),
    .ones     (bcd_one)
  );

  assign addr_k = i_q + ADDR_W'(k_q);

  always_comb begin
    case (k_q[1:0])
      2'd0:    digit = bcd_hun;
      2'd1:    digit = bcd_ten;
      default: digit = bcd_one;
    endcase
  end

  // Next state, counter, protection flag and all port-side outputs.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    prot_d    = prot_q;
    cmd_ready = 1'b0;
    rf_raddr  = 4'd0;
    rf_we     = 1'b0;
    rf_waddr  = 4'd0;
    rf_wdata  = 8'd0;
    mem_en    = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'd0;
    done      = 1'b0;
    prot_hit  = 1'b0;
    i_next    = '0;
    i_we      = 1'b0;

    cmd_ready = ~rst & ((state_q == IDLE) | (state_q == DONE));
    accept    = cmd_valid & cmd_ready;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = op_to_state(op_e'(cmd_op));
          k_d     = 4'd0;
          prot_d  = 1'b0;
        end
      end
      STORE: begin
        rf_raddr  = k_q;
        mem_en    = 1'b1;
        mem_write = 1'b1;
        mem_addr  = addr_k;
        mem_wdata = rf_rdata;
        if (addr_k < PROT_LIMIT) prot_d = 1'b1;
        k_d = k_q + 4'd1;
        if (k_q == x_q) state_d = DONE;
      end
      LOAD: begin
        // Read data returns one cycle late, so each cycle retires the previous read.
        mem_en   = 1'b1;
        mem_addr = addr_k;
        if (k_q != 4'd0) begin
          rf_we    = 1'b1;
          rf_waddr = k_q - 4'd1;
          rf_wdata = mem_rdata;
        end
        k_d = k_q + 4'd1;
        if (k_q == x_q) state_d = LOAD_LAST;
      end
      LOAD_LAST: begin
        rf_we    = 1'b1;
        rf_waddr = k_q - 4'd1;
        rf_wdata = mem_rdata;
        state_d  = DONE;
      end
      BCD: begin
        mem_en    = 1'b1;
        mem_write = 1'b1;
        mem_addr  = addr_k;
        mem_wdata = {4'd0, digit};
        if (addr_k < PROT_LIMIT) prot_d = 1'b1;
        k_d = k_q + 4'd1;
        if (k_q[1:0] == 2'd2) state_d = DONE;
      end
      DONE: begin
        done     = 1'b1;
        prot_hit = prot_q;
`ifdef CHIP8_MEM_XFER_I_INCR_EN
        if ((op_q == OP_STORE) || (op_q == OP_LOAD)) begin
          i_next = i_q + ADDR_W'(x_q) + ADDR_W'(1);
          i_we   = 1'b1;
        end else begin
          i_next = i_q;
        end
`else
        i_next = i_q;
`endif
        // Accepting here keeps back-to-back commands gap-free.
        if (accept) begin
          state_d = op_to_state(op_e'(cmd_op));
          k_d     = 4'd0;
          prot_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= 4'd0;
      x_q     <= 4'd0;
      i_q     <= '0;
      val_q   <= 8'd0;
      prot_q  <= 1'b0;
`ifdef CHIP8_MEM_XFER_I_INCR_EN
      op_q    <= OP_NOP;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      prot_q  <= prot_d;
      if (accept) begin
        x_q   <= cmd_x;
        i_q   <= cmd_i;
        val_q <= cmd_val;
`ifdef CHIP8_MEM_XFER_I_INCR_EN
        op_q  <= op_e'(cmd_op);
`endif
      end
    end
  end

endmodule

// File: tb/tb_chip8_mem_xfer.sv
// Self-checking bench for chip8_mem_xfer: table of directed commands plus reset and back-to-back sequences.
module tb_chip8_mem_xfer;
  import chip8_pkg::*;

`ifdef CHIP8_MEM_XFER_I_INCR_EN
  localparam bit INCR = 1'b1;
`else
  localparam bit INCR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [3:0]  cmd_x = 4'd0;
  logic [11:0] cmd_i = 12'd0;
  logic [7:0]  cmd_val = 8'd0;
  logic [3:0]  rf_raddr;
  logic [7:0]  rf_rdata;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [7:0]  rf_wdata;
  logic        mem_en;
  logic        mem_write;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'd0;
  logic        done;
  logic        prot_hit;
  logic [11:0] i_next;
  logic        i_we;

  logic [7:0]  mem [0:4095];
  logic [7:0]  rf  [0:15];
  logic        tb_init = 1'b1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  chip8_mem_xfer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x     (cmd_x),
    .cmd_i     (cmd_i),
    .cmd_val   (cmd_val),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .mem_en    (mem_en),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .done      (done),
    .prot_hit  (prot_hit),
    .i_next    (i_next),
    .i_we      (i_we)
  );

  assign rf_rdata = rf[rf_raddr];

  // Memory with 1-cycle read latency that drops writes below 0x200; register file.
  always @(posedge clk) begin
    if (tb_init) begin
      for (int a = 0; a < 4096; a++) mem[a] <= 8'h00;
      for (int n = 0; n < 16; n++) mem[12'h400 + n] <= 8'(n);
      mem[12'h500] <= 8'hFF;
      mem[12'h601] <= 8'hFF;
      for (int n = 0; n < 16; n++) rf[n] <= 8'(8'hA0 + n);
      rf[0] <= 8'h11;
      rf[1] <= 8'h22;
      rf[2] <= 8'h33;
    end else begin
      if (mem_en) begin
        if (mem_write) begin
          if (mem_addr >= 12'h200) mem[mem_addr] <= mem_wdata;
        end else begin
          mem_rdata <= mem[mem_addr];
        end
      end
      if (rf_we) rf[rf_waddr] <= rf_wdata;
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  x;
    logic [11:0] i;
    logic [7:0]  val;
    int          lat;
    logic        prot;
    logic [11:0] inext;
    logic        iwe;
    int          nwr;
    int          nrf;
    int          kind;   // 0 none, 1 memory byte, 2 register
    logic [11:0] caddr;
    logic [7:0]  cdata;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] op, input logic [3:0] x, input logic [11:0] i,
                              input logic [7:0] val, input int lat, input logic prot,
                              input logic [11:0] inext, input logic iwe, input int nwr,
                              input int nrf, input int kind, input logic [11:0] caddr,
                              input logic [7:0] cdata);
    vec_t v;
    v.op = op; v.x = x; v.i = i; v.val = val; v.lat = lat; v.prot = prot;
    v.inext = inext; v.iwe = iwe; v.nwr = nwr; v.nrf = nrf; v.kind = kind;
    v.caddr = caddr; v.cdata = cdata;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int  n;
    int  nwr;
    int  nrf;
    bit  got;
    @(negedge clk);
    chk({tag, "_ready"}, int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_x     = v.x;
    cmd_i     = v.i;
    cmd_val   = v.val;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0; nwr = 0; nrf = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (mem_en && mem_write) nwr++;
      if (rf_we) nrf++;
      if (done) begin
        got = 1'b1;
        chk({tag, "_prot"},  int'(prot_hit), int'(v.prot));
        chk({tag, "_inext"}, int'(i_next),   int'(v.inext));
        chk({tag, "_iwe"},   int'(i_we),     int'(v.iwe));
      end
    end
    chk({tag, "_lat"}, n,   v.lat);
    chk({tag, "_nwr"}, nwr, v.nwr);
    chk({tag, "_nrf"}, nrf, v.nrf);
    if (v.kind == 1)      chk({tag, "_mem"}, int'(mem[v.caddr]),     int'(v.cdata));
    else if (v.kind == 2) chk({tag, "_rf"},  int'(rf[v.caddr[3:0]]), int'(v.cdata));
  endtask

  initial begin
    vec_t vt [8];
    int   cnt;

    vt[0] = mk(OP_STORE, 4'd2,  12'h300, 8'd0,   4,  1'b0, INCR ? 12'h303 : 12'h300, INCR, 3, 0,  1, 12'h302, 8'h33);
    vt[1] = mk(OP_BCD,   4'd0,  12'h350, 8'd254, 4,  1'b0, 12'h350,                  1'b0, 3, 0,  1, 12'h350, 8'h02);
    vt[2] = mk(OP_STORE, 4'd1,  12'hFFF, 8'd0,   3,  1'b1, INCR ? 12'h001 : 12'hFFF, INCR, 2, 0,  1, 12'hFFF, 8'h11);
    vt[3] = mk(OP_LOAD,  4'd15, 12'h400, 8'd0,   18, 1'b0, INCR ? 12'h410 : 12'h400, INCR, 0, 16, 2, 12'h00F, 8'h0F);
    vt[4] = mk(OP_NOP,   4'd5,  12'h123, 8'd0,   1,  1'b0, 12'h123,                  1'b0, 0, 0,  0, 12'h000, 8'h00);
    vt[5] = mk(OP_BCD,   4'd0,  12'h1FE, 8'd109, 4,  1'b1, 12'h1FE,                  1'b0, 3, 0,  1, 12'h200, 8'h09);
    vt[6] = mk(OP_STORE, 4'd0,  12'h500, 8'd0,   2,  1'b0, INCR ? 12'h501 : 12'h500, INCR, 1, 0,  1, 12'h500, 8'h00);
    vt[7] = mk(OP_LOAD,  4'd0,  12'h302, 8'd0,   3,  1'b0, INCR ? 12'h303 : 12'h302, INCR, 0, 1,  2, 12'h000, 8'h33);

    // Reset state
    @(posedge clk);
    #1 tb_init = 1'b0;
    @(negedge clk);
    chk("rst_ready_low", int'(cmd_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready",  int'(cmd_ready), 1);
    chk("rst_done",   int'(done),      0);
    chk("rst_mem_en", int'(mem_en),    0);
    chk("rst_rf_we",  int'(rf_we),     0);
    chk("rst_i_we",   int'(i_we),      0);
    chk("rst_i_next", int'(i_next),    0);
    chk("rst_addr",   int'(mem_addr),  0);
    chk("rst_prot",   int'(prot_hit),  0);

    for (int v = 0; v < 8; v++) run_vec($sformatf("vec%0d", v), vt[v]);

    // Reset asserted in cycle 3 of a LOAD with X=7
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_x = 4'd7; cmd_i = 12'h400; cmd_val = 8'd0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 chk("mid_rst_ready_low", int'(cmd_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready",  int'(cmd_ready), 1);
    chk("mid_rst_rf_we",  int'(rf_we),     0);
    chk("mid_rst_mem_en", int'(mem_en),    0);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (rf_we || done || mem_en) cnt++;
    end
    chk("mid_rst_quiet", cnt, 0);
    run_vec("post_rst", mk(OP_STORE, 4'd1, 12'h600, 8'd0, 3, 1'b0, INCR ? 12'h602 : 12'h600,
                           INCR, 2, 0, 1, 12'h601, 8'h01));

    // Back-to-back: BCD then NOP with cmd_valid held
    @(negedge clk);
    chk("b2b_ready0", int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_op = OP_BCD; cmd_x = 4'd0; cmd_i = 12'h700; cmd_val = 8'd37;
    @(posedge clk);
    #1 begin cmd_op = OP_NOP; cmd_i = 12'h123; cmd_val = 8'd0; end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c < 4) begin
        chk($sformatf("b2b_ready_c%0d", c), int'(cmd_ready), 0);
        chk($sformatf("b2b_done_c%0d", c),  int'(done),      0);
      end else begin
        chk("b2b_bcd_done",  int'(done),      1);
        chk("b2b_bcd_ready", int'(cmd_ready), 1);
        chk("b2b_bcd_iwe",   int'(i_we),      0);
      end
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_nop_done",  int'(done),   1);
    chk("b2b_nop_inext", int'(i_next), 12'h123);
    @(negedge clk);
    chk("b2b_after_done",  int'(done),      0);
    chk("b2b_after_ready", int'(cmd_ready), 1);
    chk("b2b_mem_tens",    int'(mem[12'h701]), 3);
    chk("b2b_mem_ones",    int'(mem[12'h702]), 7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
